// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the instruction-phase sequencer.
//   phase_state_e        : FSM state encoding (3 bits, IDLE = 0)
//   MEM_WAIT_MAX_DEFAULT : default MEM cycles tolerated without mem_ready
//   CNT_W_DEFAULT        : default performance-counter width
//   MEM_TMR_W            : width of the MEM wait timer (covers 1..255)
package phase_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXEC      = 3'd3,
    ST_EXEC_WAIT = 3'd4,
    ST_MEM       = 3'd5,
    ST_WB        = 3'd6
  } phase_state_e;

  localparam int unsigned MEM_WAIT_MAX_DEFAULT = 15;
  localparam int unsigned CNT_W_DEFAULT        = 32;
  localparam int unsigned MEM_TMR_W            = 8;

endpackage

// File: rtl/phase_sequencer_if.sv
// Handshake/strobe bundle between the phase sequencer and the core.
// Macro PHASE_SEQ_PERF_EN adds the three performance counters.
//   slave  : sequencer side (inputs run, alu_multi, mem_req, alu_complete,
//            mem_ready, err_clr; outputs en_*, alu_start, busy, mem_timeout)
//   master : core / driver side (mirror image of slave)
interface phase_sequencer_if #(
  parameter int unsigned CNT_W = 32
);
  logic run;
  logic alu_multi;
  logic mem_req;
  logic alu_complete;
  logic mem_ready;
  logic err_clr;
  logic en_fetch;
  logic en_decode;
  logic en_exec;
  logic en_mem;
  logic en_wb;
  logic alu_start;
  logic busy;
  logic mem_timeout;
`ifdef PHASE_SEQ_PERF_EN
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] retire_cnt;
`endif

  modport master (
    output run, alu_multi, mem_req, alu_complete, mem_ready, err_clr,
    input  en_fetch, en_decode, en_exec, en_mem, en_wb, alu_start, busy,
           mem_timeout
`ifdef PHASE_SEQ_PERF_EN
    , input cycle_cnt, stall_cnt, retire_cnt
`endif
  );

  modport slave (
    input  run, alu_multi, mem_req, alu_complete, mem_ready, err_clr,
    output en_fetch, en_decode, en_exec, en_mem, en_wb, alu_start, busy,
           mem_timeout
`ifdef PHASE_SEQ_PERF_EN
    , output cycle_cnt, stall_cnt, retire_cnt
`endif
  );

endinterface

// File: rtl/phase_sequencer_perf.sv
// Performance counters for the phase sequencer, instantiated only when
// PHASE_SEQ_PERF_EN is defined. All counters wrap and clear only on rst.
//   busy_pulse   : +1 cycle_cnt
//   stall_pulse  : +1 stall_cnt
//   retire_pulse : +1 retire_cnt
module phase_seq_perf #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_100M,
  input  logic             rst,
  input  logic             busy_pulse,
  input  logic             stall_pulse,
  input  logic             retire_pulse,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  logic [CNT_W-1:0] cycle_cnt_q,  cycle_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    cycle_cnt_d  = cycle_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    retire_cnt_d = retire_cnt_q;
    if (busy_pulse)   cycle_cnt_d  = cycle_cnt_q  + 1'b1;
    if (stall_pulse)  stall_cnt_d  = stall_cnt_q  + 1'b1;
    if (retire_pulse) retire_cnt_d = retire_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      cycle_cnt_q  <= '0;
      stall_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign cycle_cnt  = cycle_cnt_q;
  assign stall_cnt  = stall_cnt_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: rtl/phase_sequencer.sv
// Multi-cycle instruction-phase controller. Steps each instruction through
// FETCH, DECODE, EXEC, (EXEC_WAIT), (MEM), WB and issues single-cycle enable
// strobes on clk_100M. MEM waits on mem_ready with a bounded timeout that
// aborts the instruction and raises a sticky mem_timeout flag.
// Optional macro PHASE_SEQ_PERF_EN adds cycle/stall/retire counters.
// Ports:
//   clk_100M : system clock
//   rst      : asynchronous active-high reset
//   ps       : phase_sequencer_if.slave (handshakes, strobes, flags, counters)
//
// state      | meaning
// -----------+---------------------------------------------------
// IDLE       | waiting for run with no pending memory timeout
// FETCH      | en_fetch strobe
// DECODE     | en_decode strobe, latch alu_multi / mem_req
// EXEC       | en_exec strobe, alu_start if multicycle op
// EXEC_WAIT  | waiting for alu_complete (no timeout)
// MEM        | en_mem every cycle, waiting for mem_ready or timeout
// WB         | en_wb strobe, then FETCH if run else IDLE
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = MEM_WAIT_MAX_DEFAULT,
  parameter int unsigned CNT_W        = CNT_W_DEFAULT
) (
  input logic               clk_100M,
  input logic               rst,
  phase_sequencer_if.slave  ps
);

  phase_state_e state_q, state_d;
  logic op_multi_q, op_multi_d;
  logic op_mem_q, op_mem_d;
  logic [MEM_TMR_W-1:0] timer_q, timer_d;
  logic mem_timeout_q, mem_timeout_d;

  logic en_fetch_q, en_fetch_d;
  logic en_decode_q, en_decode_d;
  logic en_exec_q, en_exec_d;
  logic en_mem_q, en_mem_d;
  logic en_wb_q, en_wb_d;
  logic alu_start_q, alu_start_d;
  logic busy_q, busy_d;

  localparam logic [MEM_TMR_W-1:0] TMR_LIMIT = MEM_TMR_W'(MEM_WAIT_MAX);

  always_comb begin
    state_d       = state_q;
    op_multi_d    = op_multi_q;
    op_mem_d      = op_mem_q;
    timer_d       = '0;
    mem_timeout_d = mem_timeout_q;

    // Clear first so that a timeout raised this same cycle overrides it.
    if (ps.err_clr) mem_timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ps.run && !mem_timeout_q) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        op_multi_d = ps.alu_multi;
        op_mem_d   = ps.mem_req;
        state_d    = ST_EXEC;
      end
      ST_EXEC: begin
        if (op_multi_q)    state_d = ST_EXEC_WAIT;
        else if (op_mem_q) state_d = ST_MEM;
        else               state_d = ST_WB;
      end
      ST_EXEC_WAIT: begin
        if (ps.alu_complete) state_d = op_mem_q ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        if (ps.mem_ready) begin
          state_d = ST_WB;
        end else if (timer_q == TMR_LIMIT) begin
          // Abort: instruction never reaches WB.
          mem_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_WB: state_d = ps.run ? ST_FETCH : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Strobes are registered decodes of the upcoming state, so they line up
    // exactly with the state register and never glitch.
    en_fetch_d  = (state_d == ST_FETCH);
    en_decode_d = (state_d == ST_DECODE);
    en_exec_d   = (state_d == ST_EXEC);
    en_mem_d    = (state_d == ST_MEM);
    en_wb_d     = (state_d == ST_WB);
    alu_start_d = (state_d == ST_EXEC) && op_multi_d;
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      op_multi_q    <= 1'b0;
      op_mem_q      <= 1'b0;
      timer_q       <= '0;
      mem_timeout_q <= 1'b0;
      en_fetch_q    <= 1'b0;
      en_decode_q   <= 1'b0;
      en_exec_q     <= 1'b0;
      en_mem_q      <= 1'b0;
      en_wb_q       <= 1'b0;
      alu_start_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_multi_q    <= op_multi_d;
      op_mem_q      <= op_mem_d;
      timer_q       <= timer_d;
      mem_timeout_q <= mem_timeout_d;
      en_fetch_q    <= en_fetch_d;
      en_decode_q   <= en_decode_d;
      en_exec_q     <= en_exec_d;
      en_mem_q      <= en_mem_d;
      en_wb_q       <= en_wb_d;
      alu_start_q   <= alu_start_d;
      busy_q        <= busy_d;
    end
  end

  assign ps.en_fetch    = en_fetch_q;
  assign ps.en_decode   = en_decode_q;
  assign ps.en_exec     = en_exec_q;
  assign ps.en_mem      = en_mem_q;
  assign ps.en_wb       = en_wb_q;
  assign ps.alu_start   = alu_start_q;
  assign ps.busy        = busy_q;
  assign ps.mem_timeout = mem_timeout_q;

`ifdef PHASE_SEQ_PERF_EN
  logic stall_pulse;
  assign stall_pulse = (state_q == ST_EXEC_WAIT) ||
                       ((state_q == ST_MEM) && !ps.mem_ready);

  phase_seq_perf #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk_100M     (clk_100M),
    .rst          (rst),
    .busy_pulse   (busy_q),
    .stall_pulse  (stall_pulse),
    .retire_pulse (en_wb_q),
    .cycle_cnt    (ps.cycle_cnt),
    .stall_cnt    (ps.stall_cnt),
    .retire_cnt   (ps.retire_cnt)
  );
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Testbench for phase_sequencer. Each scenario pushes its expected per-cycle
// phase trace into a queue as it starts driving stimulus, then pops one entry
// per clock and compares it with the observed strobes.
// Trace letters: I idle, F fetch, D decode, E exec, X exec+alu_start,
// W exec_wait, M mem, B writeback.
module tb_phase_sequencer;

  localparam int unsigned CNT_W = 32;

  logic clk = 1'b0;
  logic rst;

  int errors = 0;
  int checks = 0;

  byte exp_q[$];

  phase_sequencer_if #(.CNT_W(CNT_W)) ps_if ();

  phase_sequencer #(
    .MEM_WAIT_MAX (3),
    .CNT_W        (CNT_W)
  ) dut (
    .clk_100M (clk),
    .rst      (rst),
    .ps       (ps_if)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // {busy, alu_start, en_wb, en_mem, en_exec, en_decode, en_fetch}
  function automatic logic [6:0] obs_vec();
    return {ps_if.busy, ps_if.alu_start, ps_if.en_wb, ps_if.en_mem,
            ps_if.en_exec, ps_if.en_decode, ps_if.en_fetch};
  endfunction

  function automatic logic [6:0] exp_vec(input byte c);
    case (c)
      "F":     return 7'b1000001;
      "D":     return 7'b1000010;
      "E":     return 7'b1000100;
      "X":     return 7'b1100100;
      "W":     return 7'b1000000;
      "M":     return 7'b1001000;
      "B":     return 7'b1010000;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic push_trace(input string s);
    for (int k = 0; k < s.len(); k++) exp_q.push_back(s.getc(k));
  endtask

  task automatic clear_inputs();
    ps_if.run          = 1'b0;
    ps_if.alu_multi    = 1'b0;
    ps_if.mem_req      = 1'b0;
    ps_if.alu_complete = 1'b0;
    ps_if.mem_ready    = 1'b0;
    ps_if.err_clr      = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    clear_inputs();
    rst = 1'b1;
    #1;
    got = obs_vec();
    checks++;
    if (got !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", got, 7'b0);
    end
    checks++;
    if (ps_if.mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_timeout: got %b want 0", ps_if.mem_timeout);
    end
`ifdef PHASE_SEQ_PERF_EN
    checks++;
    if ((ps_if.cycle_cnt | ps_if.stall_cnt | ps_if.retire_cnt) !== '0) begin
      errors++;
      $display("FAIL reset_counters: got %0h/%0h/%0h want 0/0/0",
               ps_if.cycle_cnt, ps_if.stall_cnt, ps_if.retire_cnt);
    end
`endif
    // run held during reset must not start anything
    ps_if.run = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    got = obs_vec();
    checks++;
    if (got !== 7'b0) begin
      errors++;
      $display("FAIL reset_hold: got %b want %b", got, 7'b0);
    end
    ps_if.run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    push_trace("II");
    for (int i = 1; i <= 2; i++) begin
      logic [6:0] want;
      @(posedge clk); #1;
      got  = obs_vec();
      want = exp_vec(exp_q.pop_front());
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: got %b want %b", i, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    string tr = "FDEBFDEBFDEBII";
    logic [6:0] got, want;
    logic [CNT_W-1:0] c0, s0, r0;
`ifdef PHASE_SEQ_PERF_EN
    c0 = ps_if.cycle_cnt; s0 = ps_if.stall_cnt; r0 = ps_if.retire_cnt;
`else
    c0 = '0; s0 = '0; r0 = '0;
`endif
    clear_inputs();
    push_trace(tr);
    for (int i = 1; i <= tr.len(); i++) begin
      ps_if.run = (i <= 9);
      @(posedge clk); #1;
      got  = obs_vec();
      want = exp_vec(exp_q.pop_front());
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL back_to_back cyc%0d: got %b want %b", i, got, want);
      end
    end
`ifdef PHASE_SEQ_PERF_EN
    checks++;
    if ((ps_if.retire_cnt - r0) !== CNT_W'(3)) begin
      errors++;
      $display("FAIL b2b_retire: got %0d want 3", ps_if.retire_cnt - r0);
    end
    checks++;
    if ((ps_if.cycle_cnt - c0) !== CNT_W'(12)) begin
      errors++;
      $display("FAIL b2b_cycles: got %0d want 12", ps_if.cycle_cnt - c0);
    end
    checks++;
    if ((ps_if.stall_cnt - s0) !== CNT_W'(0)) begin
      errors++;
      $display("FAIL b2b_stall: got %0d want 0", ps_if.stall_cnt - s0);
    end
`endif
  endtask

  task automatic test_multicycle();
    string tr = "FDXWWWBI";
    logic [6:0] got, want;
    logic [CNT_W-1:0] s0, r0;
`ifdef PHASE_SEQ_PERF_EN
    s0 = ps_if.stall_cnt; r0 = ps_if.retire_cnt;
`else
    s0 = '0; r0 = '0;
`endif
    clear_inputs();
    push_trace(tr);
    for (int i = 1; i <= tr.len(); i++) begin
      ps_if.run          = (i == 1);
      ps_if.alu_multi    = 1'b1;
      // complete during EXEC (ignored) and on the 3rd EXEC_WAIT cycle
      ps_if.alu_complete = (i == 4) || (i == 7);
      @(posedge clk); #1;
      got  = obs_vec();
      want = exp_vec(exp_q.pop_front());
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL multicycle cyc%0d: got %b want %b", i, got, want);
      end
    end
`ifdef PHASE_SEQ_PERF_EN
    checks++;
    if ((ps_if.stall_cnt - s0) !== CNT_W'(3)) begin
      errors++;
      $display("FAIL multi_stall: got %0d want 3", ps_if.stall_cnt - s0);
    end
    checks++;
    if ((ps_if.retire_cnt - r0) !== CNT_W'(1)) begin
      errors++;
      $display("FAIL multi_retire: got %0d want 1", ps_if.retire_cnt - r0);
    end
`endif
  endtask

  task automatic test_mem_wait();
    string tr = "FDEMMBI";
    logic [6:0] got, want;
    logic [CNT_W-1:0] s0;
`ifdef PHASE_SEQ_PERF_EN
    s0 = ps_if.stall_cnt;
`else
    s0 = '0;
`endif
    clear_inputs();
    push_trace(tr);
    for (int i = 1; i <= tr.len(); i++) begin
      ps_if.run       = (i == 1);
      ps_if.mem_req   = 1'b1;
      // ready during EXEC must be ignored; real ready on 2nd MEM cycle
      ps_if.mem_ready = (i == 4) || (i == 6);
      @(posedge clk); #1;
      got  = obs_vec();
      want = exp_vec(exp_q.pop_front());
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL mem_wait cyc%0d: got %b want %b", i, got, want);
      end
    end
`ifdef PHASE_SEQ_PERF_EN
    checks++;
    if ((ps_if.stall_cnt - s0) !== CNT_W'(1)) begin
      errors++;
      $display("FAIL mem_stall: got %0d want 1", ps_if.stall_cnt - s0);
    end
`endif
  endtask

  task automatic test_mem_timeout();
    string tr = "FDEMMMMIIIIFDEBI";
    logic [6:0] got, want;
    logic exp_to;
    logic [CNT_W-1:0] s0, r0;
`ifdef PHASE_SEQ_PERF_EN
    s0 = ps_if.stall_cnt; r0 = ps_if.retire_cnt;
`else
    s0 = '0; r0 = '0;
`endif
    clear_inputs();
    push_trace(tr);
    for (int i = 1; i <= tr.len(); i++) begin
      ps_if.run     = (i <= 12);
      ps_if.mem_req = (i <= 3);
      // err_clr coincides with the abort (set wins), then clears later
      ps_if.err_clr = (i == 8) || (i == 11);
      @(posedge clk); #1;
      got    = obs_vec();
      want   = exp_vec(exp_q.pop_front());
      exp_to = (i >= 8) && (i <= 10);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL timeout_trace cyc%0d: got %b want %b", i, got, want);
      end
      checks++;
      if (ps_if.mem_timeout !== exp_to) begin
        errors++;
        $display("FAIL timeout_flag cyc%0d: got %b want %b",
                 i, ps_if.mem_timeout, exp_to);
      end
    end
`ifdef PHASE_SEQ_PERF_EN
    checks++;
    if ((ps_if.stall_cnt - s0) !== CNT_W'(4)) begin
      errors++;
      $display("FAIL timeout_stall: got %0d want 4", ps_if.stall_cnt - s0);
    end
    checks++;
    if ((ps_if.retire_cnt - r0) !== CNT_W'(1)) begin
      errors++;
      $display("FAIL timeout_retire: got %0d want 1", ps_if.retire_cnt - r0);
    end
`endif
  endtask

  task automatic test_run_drop();
    string tr = "FDEBII";
    logic [6:0] got, want;
    clear_inputs();
    push_trace(tr);
    for (int i = 1; i <= tr.len(); i++) begin
      ps_if.run = (i <= 2);
      @(posedge clk); #1;
      got  = obs_vec();
      want = exp_vec(exp_q.pop_front());
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL run_drop cyc%0d: got %b want %b", i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    string tr1 = "FDXWW";
    string tr2 = "FDEBI";
    logic [6:0] got, want;
    clear_inputs();
    push_trace(tr1);
    for (int i = 1; i <= tr1.len(); i++) begin
      ps_if.run       = (i == 1);
      ps_if.alu_multi = 1'b1;
      @(posedge clk); #1;
      got  = obs_vec();
      want = exp_vec(exp_q.pop_front());
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid_pre cyc%0d: got %b want %b", i, got, want);
      end
    end
    #1;
    rst = 1'b1;
    #1;
    got = obs_vec();
    checks++;
    if (got !== 7'b0) begin
      errors++;
      $display("FAIL reset_mid_async: got %b want %b", got, 7'b0);
    end
`ifdef PHASE_SEQ_PERF_EN
    checks++;
    if ((ps_if.cycle_cnt | ps_if.stall_cnt | ps_if.retire_cnt) !== '0) begin
      errors++;
      $display("FAIL reset_mid_counters: got %0h/%0h/%0h want 0/0/0",
               ps_if.cycle_cnt, ps_if.stall_cnt, ps_if.retire_cnt);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    push_trace(tr2);
    for (int i = 1; i <= tr2.len(); i++) begin
      ps_if.run = (i == 1);
      @(posedge clk); #1;
      got  = obs_vec();
      want = exp_vec(exp_q.pop_front());
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid_post cyc%0d: got %b want %b", i, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_multicycle();
    test_mem_wait();
    test_mem_timeout();
    test_run_drop();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
